// File: rtl/dlc_skid_buf.sv
// ---------------------------------------------------------------------------
// dlc_skid_buf
//   Two-entry valid/ready register slice (skid buffer) for DL datapaths.
//   It breaks the combinational ready path between a producer and a
//   consumer, sustains one transfer per cycle, and absorbs one beat of
//   downstream backpressure in the skid register. out_valid, out_data and
//   in_ready all come straight from flops.
//
// Parameters
//   width  payload width in bits
//   rstv   value loaded into out_data (and the skid register) on reset
//
// Ports
//   clk        in   1      single clock, all state on rising edge
//   reset      in   1      synchronous, active-high reset
//   flush      in   1      synchronous discard of all held entries
//   in_valid   in   1      producer has data
//   in_ready   out  1      buffer can accept; transfer when in_valid&in_ready
//   in_data    in   width  producer payload
//   out_valid  out  1      out_data holds a valid entry
//   out_ready  in   1      consumer takes; transfer when out_valid&out_ready
//   out_data   out  width  head-of-buffer payload
//   occupancy  out  2      entries held: 0, 1 or 2
// ---------------------------------------------------------------------------
module dlc_skid_buf #(
  parameter int               width = 1,
  parameter logic [width-1:0] rstv  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [width-1:0] main_q;
  logic [width-1:0] skid_q;
  logic             valid_q;
  logic             ready_q;

  logic             in_acc;
  logic             out_acc;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  // Handshakes use only the registered ready/valid, so no input ever
  // reaches an output combinationally.
  assign in_acc  = in_valid & ready_q;
  assign out_acc = valid_q & out_ready;

  // Next-state and data-register load selection. Flush overrides any
  // same-cycle handshake, so neither beat moves any data.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_acc) begin
            next_state   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            next_state   = ONE;
            load_main_in = 1'b1;
          end else if (in_acc) begin
            next_state = FULL;
            load_skid  = 1'b1;
          end else if (out_acc) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the consumer side can move.
          if (out_acc) begin
            next_state     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
    end
  end

  // State, registered handshake outputs and payload registers. in_ready is
  // held low during reset and only rises on the first edge after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      main_q  <= rstv;
      skid_q  <= rstv;
    end else begin
      state   <= next_state;
      valid_q <= (next_state != EMPTY);
      ready_q <= (next_state != FULL);
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  // Occupancy is decoded from the state register, so it is glitch-free
  // and carries no input path.
  always_comb begin
    occupancy = 2'd0;
    unique case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_valid = valid_q;
  assign in_ready  = ready_q;
  assign out_data  = main_q;

endmodule
